// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life generation engine.
//   Cell bit layout, rule constants and the engine state encoding.
package gol_pkg;

   // Cell word layout: {age[1:0], next, alive}
   localparam int ALIVE_B = 0;
   localparam int NEXT_B  = 1;
   localparam int AGE_LSB = 2;

   localparam logic [1:0] AGE_MAX = 2'd3;

   // B3/S23
   localparam logic [3:0] BIRTH_N    = 4'd3;
   localparam logic [3:0] SURVIVE_LO = 4'd2;
   localparam logic [3:0] SURVIVE_HI = 4'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRIME  = 3'd1,
      S_CELL   = 3'd2,
      S_COMMIT = 3'd3,
      S_FIN    = 3'd4
   } state_e;

endpackage

// File: rtl/gol_step_engine_if.sv
// Handshake and RAM port-B bundle of the generation engine.
//   start    : request one generation (ignored while busy)
//   busy     : generation in progress
//   done     : one-cycle pulse after busy falls
//   ram_addr : port-B address {y, x}
//   ram_we   : port-B write enable
//   ram_din  : port-B write data
//   ram_dout : port-B read data, one cycle after ram_addr, write-first
// master = engine side, slave = controller/RAM side.
interface gol_step_engine_if #(
   parameter int W_BITS = 8,
   parameter int H_BITS = 8
);
   logic                     start;
   logic                     busy;
   logic                     done;
   logic [W_BITS+H_BITS-1:0] ram_addr;
   logic                     ram_we;
   logic [3:0]               ram_din;
   logic [3:0]               ram_dout;

   modport master (
      input  start, ram_dout,
      output busy, done, ram_addr, ram_we, ram_din
   );

   modport slave (
      output start, ram_dout,
      input  busy, done, ram_addr, ram_we, ram_din
   );
endinterface

// File: rtl/gol_rule.sv
// Conway B3/S23 rule evaluation, purely combinational.
//   nbr   : the 8 neighbour alive bits (any order)
//   alive : centre cell alive bit
//   next  : centre alive state in the next generation
//   count : number of live neighbours (0..8)
module gol_rule
   import gol_pkg::*;
(
   input  logic [7:0] nbr,
   input  logic       alive,
   output logic       next,
   output logic [3:0] count
);

   always_comb begin
      count = 4'd0;
      for (int i = 0; i < 8; i++) begin
         count = count + {3'b000, nbr[i]};
      end
      next = (count == BIRTH_N) ||
             (alive && ((count == SURVIVE_LO) || (count == SURVIVE_HI)));
   end

endmodule

// File: rtl/gol_step_engine.sv
// One-generation in-place Game-of-Life update on a toroidal grid held in
// RAM port B. COMPUTE sweeps rows with a 3x3 sliding window and writes the
// next state into bit1 of each cell; COMMIT then promotes bit1 to bit0,
// ages surviving cells and counts the population.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : start/busy/done handshake and RAM port-B signals
//   gen_count   : generations completed (wraps)
//   alive_count : population after the last completed generation
module gol_step_engine
   import gol_pkg::*;
#(
   parameter int W_BITS = 8,
   parameter int H_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   gol_step_engine_if.master        bus,
   output logic [15:0]              gen_count,
   output logic [W_BITS+H_BITS:0]   alive_count
);

   localparam int A_BITS = W_BITS + H_BITS;
   localparam logic [W_BITS-1:0] X_LAST = '1;
   localparam logic [W_BITS-1:0] X_FIRST = '0;

   function automatic logic [1:0] age_inc(input logic [1:0] age);
      return (age == AGE_MAX) ? AGE_MAX : age + 2'd1;
   endfunction

   // control state
   state_e              state_q, state_d;
   logic [W_BITS-1:0]   x_q, x_d;
   logic [H_BITS-1:0]   y_q, y_d;
   logic [2:0]          sub_q, sub_d;
   logic [A_BITS-1:0]   ca_q, ca_d;
   logic                cph_q, cph_d;
   logic [A_BITS:0]     acc_q, acc_d;
   logic [15:0]         gen_count_q, gen_count_d;
   logic [A_BITS:0]     alive_count_q, alive_count_d;

   // window: index 0 = left, 1 = centre, 2 = right column
   logic [2:0]          win_top_q, win_top_d;
   logic [2:0]          win_mid_q, win_mid_d;
   logic [2:0]          win_bot_q, win_bot_d;
   logic [1:0]          age_c_q, age_c_d;
   logic [1:0]          age_r_q, age_r_d;

   logic [A_BITS-1:0]   addr_c;
   logic                we_c;
   logic [3:0]          din_c;

   logic [W_BITS-1:0]   x_p1;
   logic [H_BITS-1:0]   y_m1, y_p1;
   logic [7:0]          nbr;
   logic                rule_next;
   logic [3:0]          nbr_cnt_unused;
   logic                cm_alive;
   logic [1:0]          cm_age;

   assign x_p1 = x_q + W_BITS'(1);
   assign y_m1 = y_q - H_BITS'(1);
   assign y_p1 = y_q + H_BITS'(1);

   // Bottom-right neighbour is taken straight off ram_dout in CELL cycle 3.
   assign nbr = {win_top_q, win_mid_q[2], win_mid_q[0],
                 win_bot_q[1:0], bus.ram_dout[ALIVE_B]};

   gol_rule u_rule (
      .nbr   (nbr),
      .alive (win_mid_q[1]),
      .next  (rule_next),
      .count (nbr_cnt_unused)
   );

   assign cm_alive = bus.ram_dout[NEXT_B];
   assign cm_age   = (cm_alive && bus.ram_dout[ALIVE_B]) ?
                     age_inc(bus.ram_dout[AGE_LSB +: 2]) : 2'd0;

   always_comb begin
      state_d         = state_q;
      x_d             = x_q;
      y_d             = y_q;
      sub_d           = sub_q;
      ca_d            = ca_q;
      cph_d           = cph_q;
      acc_d           = acc_q;
      gen_count_d     = gen_count_q;
      alive_count_d   = alive_count_q;
      win_top_d       = win_top_q;
      win_mid_d       = win_mid_q;
      win_bot_d       = win_bot_q;
      age_c_d         = age_c_q;
      age_r_d         = age_r_q;
      addr_c          = '0;
      we_c            = 1'b0;
      din_c           = 4'd0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_PRIME;
               x_d     = '0;
               y_d     = '0;
               sub_d   = 3'd0;
               acc_d   = '0;
            end
         end

         // ---- PRIME: load left/centre columns (x=W-1, x=0) ----
         S_PRIME: begin
            case (sub_q)
               3'd0: addr_c = {y_m1, X_LAST};
               3'd1: addr_c = {y_q,  X_LAST};
               3'd2: addr_c = {y_p1, X_LAST};
               3'd3: addr_c = {y_m1, X_FIRST};
               3'd4: addr_c = {y_q,  X_FIRST};
               3'd5: addr_c = {y_p1, X_FIRST};
               default: addr_c = '0;
            endcase
            // data for the read issued in sub k lands in sub k+1
            case (sub_q)
               3'd1: win_top_d[0] = bus.ram_dout[ALIVE_B];
               3'd2: win_mid_d[0] = bus.ram_dout[ALIVE_B];
               3'd3: win_bot_d[0] = bus.ram_dout[ALIVE_B];
               3'd4: win_top_d[1] = bus.ram_dout[ALIVE_B];
               3'd5: begin
                  win_mid_d[1] = bus.ram_dout[ALIVE_B];
                  age_c_d      = bus.ram_dout[AGE_LSB +: 2];
               end
               3'd6: win_bot_d[1] = bus.ram_dout[ALIVE_B];
               default: ;
            endcase
            sub_d = sub_q + 3'd1;
            if (sub_q == 3'd6) begin
               state_d = S_CELL;
               sub_d   = 3'd0;
               x_d     = '0;
            end
         end

         // ---- CELL: fetch column x+1, evaluate and write (y,x) ----
         S_CELL: begin
            sub_d = sub_q + 3'd1;
            case (sub_q)
               3'd0: addr_c = {y_m1, x_p1};
               3'd1: begin
                  addr_c       = {y_q, x_p1};
                  win_top_d[2] = bus.ram_dout[ALIVE_B];
               end
               3'd2: begin
                  addr_c       = {y_p1, x_p1};
                  win_mid_d[2] = bus.ram_dout[ALIVE_B];
                  age_r_d      = bus.ram_dout[AGE_LSB +: 2];
               end
               default: begin
                  addr_c                 = {y_q, x_q};
                  we_c                   = 1'b1;
                  // only bit1 changes, so bit0 stays generation-N for
                  // the row below and the x=W-1 wrap read of column 0
                  din_c[AGE_LSB +: 2]    = age_c_q;
                  din_c[NEXT_B]          = rule_next;
                  din_c[ALIVE_B]         = win_mid_q[1];
                  win_top_d              = {win_top_q[2], win_top_q[2:1]};
                  win_mid_d              = {win_mid_q[2], win_mid_q[2:1]};
                  win_bot_d              = {bus.ram_dout[ALIVE_B],
                                            bus.ram_dout[ALIVE_B],
                                            win_bot_q[1]};
                  age_c_d                = age_r_q;
                  sub_d                  = 3'd0;
                  x_d                    = x_p1;
                  if (x_q == X_LAST) begin
                     if (y_q == '1) begin
                        state_d = S_COMMIT;
                        ca_d    = '0;
                        cph_d   = 1'b0;
                     end else begin
                        state_d = S_PRIME;
                        y_d     = y_p1;
                     end
                  end
               end
            endcase
         end

         // ---- COMMIT: read cell, write promoted cell ----
         S_COMMIT: begin
            addr_c = ca_q;
            if (!cph_q) begin
               cph_d = 1'b1;
            end else begin
               we_c                = 1'b1;
               din_c[AGE_LSB +: 2] = cm_age;
               din_c[ALIVE_B]      = cm_alive;
               acc_d               = acc_q + (A_BITS + 1)'(cm_alive);
               ca_d                = ca_q + A_BITS'(1);
               cph_d               = 1'b0;
               if (ca_q == '1) begin
                  state_d = S_FIN;
               end
            end
         end

         // ---- FIN: publish results ----
         S_FIN: begin
            state_d       = S_IDLE;
            gen_count_d   = gen_count_q + 16'd1;
            alive_count_d = acc_q;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         x_q           <= '0;
         y_q           <= '0;
         sub_q         <= 3'd0;
         ca_q          <= '0;
         cph_q         <= 1'b0;
         acc_q         <= '0;
         gen_count_q   <= 16'd0;
         alive_count_q <= '0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         sub_q         <= sub_d;
         ca_q          <= ca_d;
         cph_q         <= cph_d;
         acc_q         <= acc_d;
         gen_count_q   <= gen_count_d;
         alive_count_q <= alive_count_d;
      end
   end

   always_ff @(posedge clk) begin
      win_top_q <= win_top_d;
      win_mid_q <= win_mid_d;
      win_bot_q <= win_bot_d;
      age_c_q   <= age_c_d;
      age_r_q   <= age_r_d;
   end

   assign bus.busy     = (state_q == S_PRIME) || (state_q == S_CELL) ||
                         (state_q == S_COMMIT);
   assign bus.done     = (state_q == S_FIN);
   assign bus.ram_addr = addr_c;
   // a reset arriving mid-write must not corrupt the grid
   assign bus.ram_we   = we_c & ~rst;
   assign bus.ram_din  = din_c;
   assign gen_count    = gen_count_q;
   assign alive_count  = alive_count_q;

endmodule

// File: tb/tb_gol_step_engine.sv
// Bench for gol_step_engine on a 16x16 torus with a write-first RAM model
// and a cell-by-cell Life reference model.
module tb_gol_step_engine;

   localparam int WB = 4;
   localparam int HB = 4;
   localparam int W = 1 << WB;
   localparam int H = 1 << HB;
   localparam int N = W * H;
   localparam int GEN_CYCLES = H * (7 + 4 * W) + 2 * W * H;
   localparam int LIM = 4000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] gen_count;
   logic [WB+HB:0] alive_count;

   always #5 clk = ~clk;

   gol_step_engine_if #(.W_BITS(WB), .H_BITS(HB)) bus ();

   gol_step_engine #(.W_BITS(WB), .H_BITS(HB)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .gen_count   (gen_count),
      .alive_count (alive_count)
   );

   // RAM port B: 1-cycle read latency, write-first
   logic [3:0] mem [N];
   logic [3:0] img [N];
   logic       load_en = 1'b0;

   always @(posedge clk) begin
      if (load_en) begin
         mem <= img;
      end else if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_din;
      end
      bus.ram_dout <= bus.ram_we ? bus.ram_din : mem[bus.ram_addr];
   end

   // reference grid
   bit ref_alive [N];
   int ref_age   [N];
   int exp_gen = 0;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int idx(input int y, input int x);
      return ((y + H) % H) * W + ((x + W) % W);
   endfunction

   function automatic logic [3:0] exp_cell(input int i);
      return {2'(ref_age[i]), 1'b0, ref_alive[i]};
   endfunction

   task automatic clear_ref();
      for (int i = 0; i < N; i++) begin
         ref_alive[i] = 1'b0;
         ref_age[i] = 0;
      end
   endtask

   task automatic push_grid(input bit junk);
      for (int i = 0; i < N; i++) begin
         img[i] = {2'(ref_age[i]), junk ? 1'($urandom_range(0, 1)) : 1'b0,
                   ref_alive[i]};
      end
      @(negedge clk) load_en = 1'b1;
      @(negedge clk) load_en = 1'b0;
   endtask

   task automatic model_step();
      bit na [N];
      int ng [N];
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            int n;
            int c;
            n = 0;
            c = idx(y, x);
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  if (dy != 0 || dx != 0) n += int'(ref_alive[idx(y + dy, x + dx)]);
            na[c] = (n == 3) || (ref_alive[c] && n == 2);
            if (na[c] && ref_alive[c]) ng[c] = (ref_age[c] >= 3) ? 3 : ref_age[c] + 1;
            else ng[c] = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         ref_alive[i] = na[i];
         ref_age[i] = ng[i];
      end
   endtask

   function automatic int population();
      int p = 0;
      for (int i = 0; i < N; i++) p += int'(ref_alive[i]);
      return p;
   endfunction

   task automatic check_grid(input string tag);
      int bad = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== exp_cell(i)) bad++;
      check_val({tag, "_grid_bad_cells"}, bad, 0);
   endtask

   // Runs one generation; when poke is set, start is also pulsed while busy
   // and in the done cycle.
   task automatic run_gen(input string tag, input bit poke);
      int busy_cyc = 0;
      int guard = 0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      while (!bus.done && guard < LIM) begin
         if (bus.busy) busy_cyc++;
         bus.start = poke && ((guard % 397) == 5);
         @(negedge clk);
         guard++;
      end
      check_val({tag, "_done_in_time"}, guard < LIM, 1);
      check_val({tag, "_busy_cycles"}, busy_cyc, GEN_CYCLES);
      bus.start = poke;
      @(negedge clk);
      bus.start = 1'b0;
      model_step();
      exp_gen++;
      check_val({tag, "_gen_count"}, gen_count, exp_gen);
      check_val({tag, "_alive_count"}, alive_count, population());
      check_grid(tag);
   endtask

   task automatic rand_grid(input int pct);
      for (int i = 0; i < N; i++) begin
         ref_alive[i] = ($urandom_range(0, 99) < pct);
         ref_age[i] = ref_alive[i] ? int'($urandom_range(0, 3)) : 0;
      end
   endtask

   initial begin
      bit g0 [N];
      int bad;
      int guard;
      int extra_busy;

      bus.start = 1'b0;
      for (int i = 0; i < N; i++) img[i] = 4'd0;
      load_en = 1'b1;
      repeat (3) @(negedge clk);
      load_en = 1'b0;
      rst = 1'b0;

      // ---- reset state ----
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_done", bus.done, 0);
      check_val("rst_we", bus.ram_we, 0);
      check_val("rst_addr", bus.ram_addr, 0);
      check_val("rst_din", bus.ram_din, 0);
      check_val("rst_gen", gen_count, 0);
      check_val("rst_alive", alive_count, 0);

      // ---- blinker ----
      clear_ref();
      for (int x = 4; x <= 6; x++) ref_alive[idx(5, x)] = 1'b1;
      push_grid(1'b0);
      run_gen("blinker", 1'b0);
      check_val("blinker_45", mem[idx(4, 5)], 4'b0001);
      check_val("blinker_55", mem[idx(5, 5)], 4'b0101);
      check_val("blinker_65", mem[idx(6, 5)], 4'b0001);
      check_val("blinker_54", mem[idx(5, 4)], 4'b0000);
      check_val("blinker_56", mem[idx(5, 6)], 4'b0000);
      check_val("blinker_pop", alive_count, 3);

      // ---- block still life, ageing ----
      clear_ref();
      ref_alive[idx(2, 2)] = 1'b1;
      ref_alive[idx(2, 3)] = 1'b1;
      ref_alive[idx(3, 2)] = 1'b1;
      ref_alive[idx(3, 3)] = 1'b1;
      push_grid(1'b0);
      for (int g = 1; g <= 4; g++) begin
         logic [1:0] a;
         a = (g < 3) ? 2'(g) : 2'd3;
         run_gen($sformatf("block%0d", g), 1'b0);
         check_val($sformatf("block%0d_cell22", g), mem[idx(2, 2)], {a, 2'b01});
         check_val($sformatf("block%0d_cell33", g), mem[idx(3, 3)], {a, 2'b01});
      end

      // ---- glider across the wrap corner ----
      clear_ref();
      ref_alive[idx(13, 14)] = 1'b1;
      ref_alive[idx(14, 15)] = 1'b1;
      ref_alive[idx(15, 13)] = 1'b1;
      ref_alive[idx(15, 14)] = 1'b1;
      ref_alive[idx(15, 15)] = 1'b1;
      for (int i = 0; i < N; i++) g0[i] = ref_alive[i];
      push_grid(1'b0);
      for (int g = 1; g <= 16; g++) begin
         run_gen($sformatf("glider%0d", g), 1'b0);
         check_val($sformatf("glider%0d_pop5", g), alive_count, 5);
      end
      // 16 generations move the glider by (+4,+4)
      bad = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            if (mem[idx(y, x)][0] !== g0[idx(y - 4, x - 4)]) bad++;
      check_val("glider_shift_bad_cells", bad, 0);

      // ---- start pulses while busy and during done ----
      rand_grid(30);
      push_grid(1'b1);
      run_gen("poke", 1'b1);
      extra_busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.busy) extra_busy++;
      end
      check_val("poke_no_second_gen", extra_busy, 0);
      check_val("poke_gen_after_idle", gen_count, exp_gen);

      // ---- reset in row 3 of COMPUTE, then a full generation ----
      rand_grid(40);
      push_grid(1'b1);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      guard = 0;
      while (!(bus.ram_we && guard >= 230) && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      check_val("midrst_reached_write", guard < 1000, 1);
      rst = 1'b1;
      #1;
      check_val("midrst_we_low", bus.ram_we, 0);
      @(negedge clk) rst = 1'b0;
      exp_gen = 0;
      check_val("midrst_busy", bus.busy, 0);
      check_val("midrst_gen", gen_count, 0);
      check_val("midrst_alive", alive_count, 0);
      run_gen("midrst", 1'b0);

      // ---- empty grid ----
      clear_ref();
      push_grid(1'b1);
      run_gen("empty", 1'b0);
      bad = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== 4'd0) bad++;
      check_val("empty_nonzero_cells", bad, 0);
      check_val("empty_pop", alive_count, 0);

      // ---- random soups ----
      for (int t = 0; t < 3; t++) begin
         rand_grid(20 + 15 * t);
         push_grid(1'b1);
         run_gen($sformatf("rand%0d", t), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
